imp_moment_unit: RTL and testbench
==================================

Name: imp_moment_unit

Overview:
- Parametrised successor to the single-statistic E[x²] accumulator in the ImprovedAILN datapath.
- Consumes a stream of signed samples in groups of N = 2^LOG2_N.
- Per group, produces E[x], E[x²] and Var = E[x²] − E[x]², ready for the LayerNorm normalisation stage.
- Uses shift-based division, a ready/valid input handshake, a synchronous group abort and a one-cycle done strobe.

Parameters:
- DATA_W, 8, sample width (signed two's complement), ≥2.
- LOG2_N, 3, log2 of group length N; ≥1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  sample valid; accepted when i_valid && o_ready at a rising edge.
- i_x  input  DATA_W  signed sample.
- i_clear  input  1  synchronous group abort.
- o_ready  output  1  unit can accept a sample this cycle.
- o_cnt  output  LOG2_N  samples accepted in current group (0..N−1).
- o_done  output  1  one-cycle strobe: o_Ex/o_Ex2/o_var updated.
- o_Ex  output  DATA_W  signed mean, floor.
- o_Ex2  output  2*DATA_W  unsigned mean square, floor.
- o_var  output  2*DATA_W  unsigned variance, clamped at 0.
- o_clamp  output  1  set with o_done when variance was negative and clamped.

Behaviour:
- Reset (i_rstn low, async): state ACC, accumulators 0, o_cnt 0, o_done 0, o_Ex/o_Ex2/o_var/o_clamp 0. Reset mid-group discards partial sums.
- Accumulators:
  - sum: signed, DATA_W+LOG2_N bits.
  - sumsq: unsigned, 2*DATA_W+LOG2_N bits; x² is computed as a full signed product.
  - Neither can overflow for any input sequence.
- FSM ACC:
  - o_ready = 1.
  - On an accepted sample: sum += x, sumsq += x², o_cnt += 1.
  - Cycles with i_valid low do not count (gaps allowed).
  - When the Nth sample is accepted, o_cnt wraps to 0 and the next state is MEAN.
- FSM MEAN:
  - o_ready = 0.
  - At the next edge: o_Ex ← sum >>> LOG2_N (arithmetic, floor toward −inf); o_Ex2 ← sumsq >> LOG2_N.
  - Accumulators cleared; next state VAR.
- FSM VAR:
  - o_ready = 0.
  - At the next edge: d = o_Ex2 − o_Ex² (signed, 2*DATA_W+2 bits).
  - o_var ← (d < 0) ? 0 : d; o_clamp ← (d < 0).
  - o_done ← 1; next state ACC.
- Latency: Nth sample accepted at edge E0; o_Ex/o_Ex2 valid after E1; o_var and o_done valid after E2.
- o_done is high for exactly the one cycle following E2. o_ready is 1 in that same cycle; a sample accepted then is sample 0 of the next group.
- Output registers hold their values until the next group's updates. o_Ex/o_Ex2 change at E1 while o_done is low, so consumers sample on o_done only.
- i_clear (sync):
  - In any state: accumulators and o_cnt cleared, state ACC, o_done 0.
  - Output registers o_Ex/o_Ex2/o_var/o_clamp unchanged; no o_done for the aborted group.
  - i_clear dominates a simultaneous i_valid; that sample is dropped.
  - i_clear in MEAN or VAR cancels the pending result. Whatever the abort point, o_done does not fire for that group.
- i_valid while o_ready = 0: ignored, not buffered. Upstream must hold the sample.
- Clamp case: floor of a negative mean can make o_Ex² exceed o_Ex2. Clamping is required, not an error.
- Extremes: all samples −2^(DATA_W−1) gives o_Ex2 = 2^(2*DATA_W−2), which fits unsigned 2*DATA_W.

Test Plan:
- Defaults; after reset, stream x = −1, −2, …, −8 with i_valid continuous → sum −36, sumsq 204. o_Ex = −5, o_Ex2 = 25, o_var = 0, o_clamp 0. o_done one cycle, 2 edges after the 8th sample accepted.
- 8× x = 127 → o_Ex 127, o_Ex2 16129, o_var 0. Then 8× x = −128 → o_Ex −128, o_Ex2 16384, o_var 0.
- Alternating +10, −10 (8 samples) with i_valid dropped every other cycle → o_cnt counts only accepted samples. o_Ex 0, o_Ex2 100, o_var 100.
- x = −1 then 7× 0 → o_Ex −1, o_Ex2 0, o_var 0, o_clamp 1.
- Back-to-back groups: i_valid held high with a new sample each cycle → o_ready low for exactly 2 cycles after each 8th sample. The sample presented in the o_done cycle is accepted as the next group's first. Second group results are correct.
- Abort and reset:
  - After 5 samples, assert i_clear together with i_valid → sample dropped, o_cnt 0, outputs keep previous values, no o_done. A following full group computes correctly.
  - Assert i_rstn low in VAR → all outputs 0 immediately, no o_done.

Source files
------------

// File: rtl/imp_moment_unit.sv
// Streaming first/second moment unit: accumulates N = 2^LOG2_N signed samples,
// then produces E[x], E[x^2] and the clamped variance E[x^2] - E[x]^2.
module imp_moment_unit #(
   parameter int DATA_W = 8,
   parameter int LOG2_N = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_valid,
   input  logic signed [DATA_W-1:0]   i_x,
   input  logic                       i_clear,
   output logic                       o_ready,
   output logic [LOG2_N-1:0]          o_cnt,
   output logic                       o_done,
   output logic signed [DATA_W-1:0]   o_Ex,
   output logic [2*DATA_W-1:0]        o_Ex2,
   output logic [2*DATA_W-1:0]        o_var,
   output logic                       o_clamp
);

   localparam int SUM_W = DATA_W + LOG2_N;
   localparam int SQ_W  = 2*DATA_W + LOG2_N;
   localparam int D_W   = 2*DATA_W + 2;

   typedef enum logic [1:0] {ST_ACC, ST_MEAN, ST_VAR} state_t;

   state_t                    state;
   logic signed [SUM_W-1:0]   sum;
   logic [SQ_W-1:0]           sumsq;
   logic signed [2*DATA_W-1:0] x_sq;
   logic signed [2*DATA_W-1:0] ex_sq;
   logic signed [D_W-1:0]     diff;
   logic                      diff_unused;

   // Squares are never negative, so the signed products can be zero-extended below.
   assign x_sq  = i_x * i_x;
   assign ex_sq = o_Ex * o_Ex;
   assign diff  = $signed({2'b00, o_Ex2}) - $signed({{2{ex_sq[2*DATA_W-1]}}, ex_sq});
   assign diff_unused = diff[2*DATA_W];

   // NOTE: o_ready is decoded straight from the state register, so it is glitch-free
   // and already valid for the same edge that would accept a sample.
   assign o_ready = (state == ST_ACC);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= ST_ACC;
         sum     <= '0;
         sumsq   <= '0;
         o_cnt   <= '0;
         o_done  <= 1'b0;
         o_Ex    <= '0;
         o_Ex2   <= '0;
         o_var   <= '0;
         o_clamp <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_clear) begin
            // Abort drops partial sums and any pending result; published outputs stay.
            state <= ST_ACC;
            sum   <= '0;
            sumsq <= '0;
            o_cnt <= '0;
         end else begin
            case (state)
               ST_ACC: begin
                  if (i_valid) begin
                     sum   <= sum + SUM_W'(i_x);
                     sumsq <= sumsq + {{LOG2_N{1'b0}}, x_sq};
                     o_cnt <= o_cnt + LOG2_N'(1);
                     if (&o_cnt) state <= ST_MEAN;
                  end
               end
               ST_MEAN: begin
                  // Slicing above the low LOG2_N bits is the floor divide by N.
                  o_Ex  <= sum[LOG2_N +: DATA_W];
                  o_Ex2 <= sumsq[SQ_W-1:LOG2_N];
                  sum   <= '0;
                  sumsq <= '0;
                  state <= ST_VAR;
               end
               ST_VAR: begin
                  o_clamp <= diff[D_W-1];
                  o_var   <= diff[D_W-1] ? '0 : diff[2*DATA_W-1:0];
                  o_done  <= 1'b1;
                  state   <= ST_ACC;
               end
               default: state <= ST_ACC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imp_moment_unit.sv
// Directed bench for imp_moment_unit with default parameters (DATA_W=8, N=8).
module tb_imp_moment_unit;

   logic              i_clk = 1'b0;
   logic              i_rstn = 1'b0;
   logic              i_valid = 1'b0;
   logic signed [7:0] i_x = '0;
   logic              i_clear = 1'b0;
   logic              o_ready;
   logic [2:0]        o_cnt;
   logic              o_done;
   logic signed [7:0] o_Ex;
   logic [15:0]       o_Ex2;
   logic [15:0]       o_var;
   logic              o_clamp;

   int n_checks = 0;
   int n_fail   = 0;
   int grp[8];
   int stall, done_acc, dseen;

   imp_moment_unit #(.DATA_W(8), .LOG2_N(3)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_x(i_x),
      .i_clear(i_clear), .o_ready(o_ready), .o_cnt(o_cnt), .o_done(o_done),
      .o_Ex(o_Ex), .o_Ex2(o_Ex2), .o_var(o_var), .o_clamp(o_clamp)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample from a falling edge and hold it until accepted.
   task automatic push(input int x, output int stalls, output int done_at_accept);
      i_valid = 1'b1;
      i_x     = 8'(x);
      stalls  = 0;
      while (!o_ready && stalls < 20) begin
         @(negedge i_clk);
         stalls++;
      end
      if (!o_ready) check("accept_timeout", 0, 1);
      done_at_accept = int'(o_done);
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic send_group();
      int s, d;
      for (int i = 0; i < 8; i++) push(grp[i], s, d);
   endtask

   task automatic expect_group(input string tag, input int ex, input int ex2,
                               input int vr, input int cl);
      int lat = 0;
      while (!o_done && lat < 8) begin
         @(negedge i_clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 2);
      check({tag, "_ex"}, o_Ex, ex);
      check({tag, "_ex2"}, o_Ex2, ex2);
      check({tag, "_var"}, o_var, vr);
      check({tag, "_clamp"}, o_clamp, cl);
      @(negedge i_clk);
      check({tag, "_done_width"}, o_done, 0);
   endtask

   task automatic watch_no_done(input string tag);
      dseen = 0;
      repeat (4) begin
         @(negedge i_clk);
         if (o_done) dseen = 1;
      end
      check(tag, dseen, 0);
   endtask

   initial begin
      #1;
      check("rst_ready", o_ready, 1);
      check("rst_cnt", o_cnt, 0);
      check("rst_done", o_done, 0);
      check("rst_ex", o_Ex, 0);
      check("rst_ex2", o_Ex2, 0);
      check("rst_var", o_var, 0);
      check("rst_clamp", o_clamp, 0);
      repeat (2) @(negedge i_clk);
      i_rstn = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < 8; i++) grp[i] = -(i + 1);
      send_group();
      expect_group("neg_ramp", -5, 25, 0, 0);

      for (int i = 0; i < 8; i++) grp[i] = 127;
      send_group();
      expect_group("max_pos", 127, 16129, 0, 0);

      for (int i = 0; i < 8; i++) grp[i] = -128;
      send_group();
      expect_group("max_neg", -128, 16384, 0, 0);

      // Gaps between samples: o_cnt counts accepted samples only.
      for (int i = 0; i < 8; i++) begin
         push((i % 2 == 0) ? 10 : -10, stall, done_acc);
         check("gap_cnt", o_cnt, (i + 1) % 8);
         if (i < 7) begin
            @(negedge i_clk);
            check("gap_cnt_hold", o_cnt, i + 1);
         end
      end
      expect_group("alt10", 0, 100, 100, 0);

      grp[0] = -1;
      for (int i = 1; i < 8; i++) grp[i] = 0;
      send_group();
      expect_group("clamp", -1, 0, 0, 1);

      // Back-to-back: 1..8 (E=4, E2=25, var 9) then -3/5 pairs (E=1, E2=17, var 16).
      for (int i = 0; i < 8; i++) push(i + 1, stall, done_acc);
      push(-3, stall, done_acc);
      check("b2b_stall", stall, 2);
      check("b2b_done_at_accept", done_acc, 1);
      check("b2b_cnt", o_cnt, 1);
      check("b2b_a_ex", o_Ex, 4);
      check("b2b_a_ex2", o_Ex2, 25);
      check("b2b_a_var", o_var, 9);
      for (int i = 1; i < 8; i++) begin
         push((i % 2 == 0) ? -3 : 5, stall, done_acc);
         check("b2b_no_stall", stall, 0);
      end
      expect_group("b2b_b", 1, 17, 16, 0);

      // Abort after 5 samples with a simultaneous valid sample.
      for (int i = 0; i < 5; i++) push(7, stall, done_acc);
      check("abort_pre_cnt", o_cnt, 5);
      i_valid = 1'b1;
      i_x     = 8'sd55;
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      i_valid = 1'b0;
      check("abort_cnt", o_cnt, 0);
      check("abort_hold_ex", o_Ex, 1);
      check("abort_hold_ex2", o_Ex2, 17);
      check("abort_hold_var", o_var, 16);
      watch_no_done("abort_no_done");
      for (int i = 0; i < 8; i++) grp[i] = i;
      send_group();
      expect_group("post_abort", 3, 17, 8, 0);

      // Abort while in MEAN cancels the pending result.
      for (int i = 0; i < 8; i++) grp[i] = 4;
      send_group();
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      check("mean_abort_ready", o_ready, 1);
      check("mean_abort_ex", o_Ex, 3);
      watch_no_done("mean_abort_no_done");

      // Reset asserted while in VAR.
      send_group();
      @(negedge i_clk);
      check("var_rst_pre_ex", o_Ex, 4);
      i_rstn = 1'b0;
      #1;
      check("var_rst_ex", o_Ex, 0);
      check("var_rst_ex2", o_Ex2, 0);
      check("var_rst_var", o_var, 0);
      check("var_rst_done", o_done, 0);
      @(negedge i_clk);
      i_rstn = 1'b1;
      watch_no_done("var_rst_no_done");
      check("var_rst_ready", o_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
